qed_dup_sequencer: RTL and testbench
====================================

# qed_dup_sequencer

Sequencer for single-instruction QED duplication. In the original phase it forwards fetched instructions to the pipeline and records each one in a circular buffer. On request it switches to the duplicate phase, replays the buffered originals in order, and flags them so the downstream mux routes them through the register/address-remapping transform. It sits between instruction fetch and the QED instruction mux and owns the choice between original, duplicate and injected NOP.

## Interface
- DEPTH, 16: buffer entries; power of two, 2..256.
- ADDR_W, log2(DEPTH): pointer width.
- NOP, 32'h00000013: instruction injected when nothing valid can be issued.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  QED enable; 0 = transparent pass-through.
- exec_dup  in  1  request to enter duplicate phase.
- stall_IF  in  1  fetch stage stalled; sequencer holds all outputs and state.
- ifu_valid  in  1  fetch presents an instruction.
- ifu_instruction  in  32  fetched instruction.
- ifu_ready  out  1  combinational; fetch transfer occurs when ifu_valid && ifu_ready.
- qic_qimux_instruction  out  32  registered instruction to the QED mux and transform.
- qimux_valid  out  1  registered; qic_qimux_instruction is a real (non-injected) instruction.
- qimux_sel  out  1  registered; 1 = apply duplicate transform, 0 = issue as-is.
- qed_done  out  1  registered, sticky; all duplicates issued.
- count  out  ADDR_W+1  registered buffer occupancy.

## Operation
- States: ORIG, DUP, DONE. Reset to ORIG.
- Reset values: qic_qimux_instruction = NOP, qimux_valid = 0, qimux_sel = 0, qed_done = 0, count = 0, wr_ptr = rd_ptr = 0. ifu_ready = 0 while rst = 1.
- The stall_IF = 1 condition overrides every rule below: ifu_ready = 0, and no state, pointer, count or output register changes.
- ena = 0, in any state:
  - ifu_ready = 1.
  - The accepted instruction is forwarded with qimux_sel = 0.
  - Nothing is written to the buffer.
  - Next state is ORIG, and pointers, count and qed_done clear.
- ORIG, ena = 1:
  - ifu_ready = !exec_dup && count < DEPTH.
  - Transfer: write buffer[wr_ptr], increment wr_ptr (wraps mod DEPTH), increment count, and forward the instruction with qimux_valid = 1 and qimux_sel = 0.
  - No transfer: drive NOP, qimux_valid = 0, qimux_sel = 0. This covers buffer full and ifu_valid = 0.
  - exec_dup = 1 with count > 0: no transfer this cycle; next state is DUP.
  - exec_dup = 1 with count = 0: request ignored; stay in ORIG and follow the normal rules, with ifu_ready = 0 for that cycle.
- DUP:
  - ifu_ready = 0.
  - Each cycle, issue buffer[rd_ptr] with qimux_valid = 1 and qimux_sel = 1, increment rd_ptr (wraps), decrement count.
  - When count goes 1 -> 0, next state is DONE. exec_dup is ignored.
- DONE:
  - ifu_ready = 0. Drive NOP, qimux_valid = 0, qimux_sel = 0.
  - qed_done = 1 and holds until rst or ena = 0.
- Duplicates are issued in exactly the same order as the originals. Buffer contents are never altered during replay.
- count never exceeds DEPTH and never underflows. DEPTH originals are accepted before backpressure applies.

## Timing
- Pass-through latency is 1 cycle: a transfer at edge t appears on qic_qimux_instruction after edge t.
- exec_dup sampled high at edge t (ORIG, count = N > 0):
  - The state is DUP after edge t.
  - The first duplicate appears after edge t+1.
  - The Nth duplicate appears after edge t+N, and the state is DONE after that same edge.
  - qed_done is 1 after edge t+N+1.
- Stall cycles insert one-for-one delay and never drop or repeat an instruction.
- rst asserted mid-DUP: all state returns to reset values at that edge, and buffer contents are discarded logically.
- ifu_ready is purely combinational from state, count, ena, exec_dup and stall_IF. It never depends on ifu_valid.

## Test plan
- Basic replay, DEPTH = 16: accept 3 instructions (32'h00508093, 32'h00112023, 32'h002081b3), then pulse exec_dup -> originals issue with sel = 0, then the same three issue in order with sel = 1 on 3 consecutive cycles, then NOP, then qed_done = 1.
- Full buffer: present 20 valid instructions -> ifu_ready drops after the 16th, count = 16, NOP with qimux_valid = 0 is issued; exec_dup -> exactly 16 duplicates, then DONE.
- Stall: assert stall_IF for 2 cycles during the 2nd duplicate -> outputs hold; the sequence resumes with no loss or repeat; qed_done is delayed by 2 cycles.
- exec_dup with empty buffer -> state stays ORIG, and the next instruction is accepted normally.
- Reset mid-DUP after 2 of 5 duplicates -> next cycle count = 0, NOP, sel = 0, qed_done = 0; a new 1-instruction run then replays only that instruction.
- ena = 0 -> ifu_ready = 1, instructions pass with sel = 0, count stays 0, and exec_dup has no effect; ena dropping in DONE clears qed_done.

Source files
------------

// File: rtl/qed_dup_sequencer.sv
// qed_dup_sequencer
// Sits between instruction fetch and the QED instruction mux. In the
// original phase it forwards fetched instructions and records each one in a
// circular buffer. On exec_dup it replays the buffered originals in order,
// flagged with qimux_sel so the mux applies the duplicate transform. When
// nothing valid can be issued it injects NOP.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   ena                    QED enable (0 = transparent pass-through)
//   exec_dup               request to enter the duplicate phase
//   stall_IF               fetch stalled: hold all state and outputs
//   ifu_valid/instruction  fetch handshake, ifu_ready is combinational
//   qic_qimux_instruction  registered instruction to the mux
//   qimux_valid            registered: instruction is real, not injected
//   qimux_sel              registered: 1 = apply duplicate transform
//   qed_done               registered, sticky: all duplicates issued
//   count                  registered buffer occupancy
module qed_dup_sequencer #(
  parameter int          DEPTH  = 16,
  parameter int          ADDR_W = $clog2(DEPTH),
  parameter logic [31:0] NOP    = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              exec_dup,
  input  logic              stall_IF,
  input  logic              ifu_valid,
  input  logic [31:0]       ifu_instruction,
  output logic              ifu_ready,
  output logic [31:0]       qic_qimux_instruction,
  output logic              qimux_valid,
  output logic              qimux_sel,
  output logic              qed_done,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {S_ORIG, S_DUP, S_DONE} state_e;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [31:0]         instr_q, instr_d;
  logic                valid_q, valid_d;
  logic                sel_q, sel_d;
  logic                done_q, done_d;
  logic [31:0]         buf_q [DEPTH];
  logic                xfer;

  // Ready depends only on control state, never on ifu_valid.
  always_comb begin
    ifu_ready = 1'b0;
    if (!rst && !stall_IF) begin
      if (!ena)                   ifu_ready = 1'b1;
      else if (state_q == S_ORIG) ifu_ready = !exec_dup && (count_q < FULL);
    end
  end

  assign xfer = ifu_valid && ifu_ready;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    sel_d    = sel_q;
    done_d   = done_q;
    if (!stall_IF) begin
      if (!ena) begin
        // Pass-through: forget any recorded run.
        state_d  = S_ORIG;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        done_d   = 1'b0;
        instr_d  = xfer ? ifu_instruction : NOP;
        valid_d  = xfer;
        sel_d    = 1'b0;
      end else begin
        case (state_q)
          S_ORIG: begin
            instr_d = xfer ? ifu_instruction : NOP;
            valid_d = xfer;
            sel_d   = 1'b0;
            if (xfer) begin
              wr_ptr_d = wr_ptr_q + 1'b1;
              count_d  = count_q + ONE;
            end
            // An empty buffer has nothing to replay, so the request is dropped.
            if (exec_dup && count_q != '0) state_d = S_DUP;
          end
          S_DUP: begin
            if (count_q != '0) begin
              instr_d  = buf_q[rd_ptr_q];
              valid_d  = 1'b1;
              sel_d    = 1'b1;
              rd_ptr_d = rd_ptr_q + 1'b1;
              count_d  = count_q - ONE;
              if (count_q == ONE) state_d = S_DONE;
            end else begin
              instr_d = NOP;
              valid_d = 1'b0;
              sel_d   = 1'b0;
              state_d = S_DONE;
            end
          end
          S_DONE: begin
            instr_d = NOP;
            valid_d = 1'b0;
            sel_d   = 1'b0;
            done_d  = 1'b1;
          end
          default: begin
            state_d = S_ORIG;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_ORIG;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      instr_q  <= NOP;
      valid_q  <= 1'b0;
      sel_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      sel_q    <= sel_d;
      done_q   <= done_d;
    end
  end

  // Buffer storage has no reset; occupancy and pointers define what is live.
  // Only ORIG-phase transfers with QED enabled are recorded.
  always_ff @(posedge clk) begin
    if (xfer && ena && state_q == S_ORIG) buf_q[wr_ptr_q] <= ifu_instruction;
  end

  assign qic_qimux_instruction = instr_q;
  assign qimux_valid           = valid_q;
  assign qimux_sel             = sel_q;
  assign qed_done              = done_q;
  assign count                 = count_q;

endmodule

// File: tb/tb_qed_dup_sequencer.sv
// Bench for qed_dup_sequencer: directed scenarios followed by randomized
// stimulus, all checked cycle by cycle against a queue-based reference model.
module tb_qed_dup_sequencer;

  localparam int          DEPTH  = 16;
  localparam int          ADDR_W = 4;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ena = 1'b0;
  logic              exec_dup = 1'b0;
  logic              stall_IF = 1'b0;
  logic              ifu_valid = 1'b0;
  logic [31:0]       ifu_instruction = '0;
  logic              ifu_ready;
  logic [31:0]       qic_qimux_instruction;
  logic              qimux_valid;
  logic              qimux_sel;
  logic              qed_done;
  logic [ADDR_W:0]   count;

  qed_dup_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP(NOP)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .ena                   (ena),
    .exec_dup              (exec_dup),
    .stall_IF              (stall_IF),
    .ifu_valid             (ifu_valid),
    .ifu_instruction       (ifu_instruction),
    .ifu_ready             (ifu_ready),
    .qic_qimux_instruction (qic_qimux_instruction),
    .qimux_valid           (qimux_valid),
    .qimux_sel             (qimux_sel),
    .qed_done              (qed_done),
    .count                 (count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase 0 = recording, 1 = replaying, 2 = finished.
  int          m_phase = 0;
  logic [31:0] m_q[$];
  logic [31:0] m_instr = NOP;
  logic        m_valid = 1'b0;
  logic        m_sel   = 1'b0;
  logic        m_done  = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic x, input logic s,
                      input logic v, input logic [31:0] ins);
    logic rdy;
    @(negedge clk);
    rst = r; ena = e; exec_dup = x; stall_IF = s; ifu_valid = v; ifu_instruction = ins;
    #1;
    if (r || s)            rdy = 1'b0;
    else if (!e)           rdy = 1'b1;
    else if (m_phase == 0) rdy = !x && (m_q.size() < DEPTH);
    else                   rdy = 1'b0;
    check_eq("ifu_ready", ifu_ready, rdy);
    @(posedge clk);
    if (r) begin
      m_phase = 0; m_q.delete(); m_instr = NOP; m_valid = 0; m_sel = 0; m_done = 0;
    end else if (!s) begin
      if (!e) begin
        m_phase = 0; m_q.delete(); m_done = 0; m_sel = 0;
        m_valid = v;
        m_instr = v ? ins : NOP;
      end else if (m_phase == 0) begin
        m_sel = 0;
        m_valid = v && rdy;
        m_instr = (v && rdy) ? ins : NOP;
        if (v && rdy) m_q.push_back(ins);
        if (x && m_q.size() > 0) m_phase = 1;
      end else if (m_phase == 1) begin
        m_instr = m_q.pop_front();
        m_valid = 1; m_sel = 1;
        if (m_q.size() == 0) m_phase = 2;
      end else begin
        m_instr = NOP; m_valid = 0; m_sel = 0; m_done = 1;
      end
    end
    #1;
    check_eq("instr", qic_qimux_instruction, m_instr);
    check_eq("valid", qimux_valid, m_valid);
    check_eq("sel", qimux_sel, m_sel);
    check_eq("done", qed_done, m_done);
    check_eq("count", count, m_q.size());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, NOP);
  endtask

  task automatic clear_run();
    step(0, 0, 0, 0, 0, NOP);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0, NOP);
    step(1, 1, 1, 0, 1, 32'h1234);
    check_eq("rst_instr", qic_qimux_instruction, NOP);
    check_eq("rst_count", count, 0);

    // Basic replay
    step(0, 1, 0, 0, 1, 32'h00508093);
    step(0, 1, 0, 0, 1, 32'h00112023);
    step(0, 1, 0, 0, 1, 32'h002081b3);
    step(0, 1, 1, 0, 0, NOP);
    step(0, 1, 0, 0, 0, NOP);
    check_eq("dup0_lit", {qimux_sel, qic_qimux_instruction}, {1'b1, 32'h00508093});
    step(0, 1, 0, 0, 0, NOP);
    check_eq("dup1_lit", {qimux_sel, qic_qimux_instruction}, {1'b1, 32'h00112023});
    step(0, 1, 0, 0, 0, NOP);
    check_eq("dup2_lit", {qimux_sel, qic_qimux_instruction}, {1'b1, 32'h002081b3});
    step(0, 1, 0, 0, 0, NOP);
    check_eq("after_dup_nop", {qimux_valid, qic_qimux_instruction}, {1'b0, NOP});
    step(0, 1, 0, 0, 0, NOP);
    check_eq("done_lit", qed_done, 1);

    // Full buffer: 20 offered, 16 accepted
    clear_run();
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 1, $urandom);
    check_eq("full_count", count, 16);
    check_eq("full_ready", ifu_ready, 0);
    step(0, 1, 1, 0, 1, $urandom);
    idle(18);

    // Stall during the 2nd duplicate
    clear_run();
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, $urandom);
    step(0, 1, 1, 0, 0, NOP);
    step(0, 1, 0, 0, 0, NOP);
    step(0, 1, 0, 1, 0, NOP);
    step(0, 1, 0, 1, 0, NOP);
    idle(5);

    // exec_dup with empty buffer
    clear_run();
    step(0, 1, 1, 0, 1, 32'hdeadbeef);
    step(0, 1, 0, 0, 1, 32'h00a00513);
    check_eq("empty_exec_accept", {qimux_valid, qic_qimux_instruction}, {1'b1, 32'h00a00513});

    // Reset mid-DUP after 2 of 5 duplicates
    clear_run();
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1, $urandom);
    step(0, 1, 1, 0, 0, NOP);
    idle(2);
    step(1, 1, 0, 0, 0, NOP);
    check_eq("rstdup_state", {count, qimux_sel, qed_done, qic_qimux_instruction},
             {5'd0, 1'b0, 1'b0, NOP});
    step(0, 1, 0, 0, 1, 32'h00100093);
    step(0, 1, 1, 0, 0, NOP);
    idle(3);

    // ena = 0 pass-through, including exec_dup and dropping ena in DONE
    for (int i = 0; i < 6; i++) step(0, 0, i[0], 0, 1, $urandom);
    check_eq("bypass_count", count, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 1, $urandom);
    step(0, 1, 1, 0, 0, NOP);
    idle(4);
    step(0, 0, 0, 0, 0, NOP);
    check_eq("ena_drop_done", qed_done, 0);

    // Randomized stimulus
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(63) == 0, $urandom_range(15) != 0, $urandom_range(9) == 0,
           $urandom_range(7) == 0, $urandom_range(3) != 0, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
